// File: rtl/imem_arbiter.sv
// Instruction memory owner: post-reset hardware clear, then one access
// per cycle shared between fetch and loader with a loader burst limit.
module imem_arbiter #(
  parameter int IMEM_BITS      = 19,
  parameter int MAX_LD_BURST   = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [IMEM_BITS-1:0] fetch_addr,
  output logic                 fetch_gnt,
  output logic                 fetch_rvalid,
  output logic [31:0]          fetch_rdata,
  input  logic                 ld_valid,
  input  logic                 ld_we,
  input  logic [IMEM_BITS-1:0] ld_addr,
  input  logic [31:0]          ld_wdata,
  output logic                 ld_ready,
  output logic                 ld_rvalid,
  output logic [31:0]          ld_rdata,
  output logic                 busy,
  output logic [IMEM_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int BW = $clog2(MAX_LD_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_LD_BURST);

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t S_INIT = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_t               r_state;
  state_t               w_next;
  logic [IMEM_BITS-1:0] r_clr_cnt;
  logic [IMEM_BITS-1:0] r_last;
  logic [BW-1:0]        r_burst;
  logic                 r_f_rv;
  logic                 r_l_rv;
  logic [31:0]          r_f_hold;
  logic [31:0]          r_l_hold;

  always_comb begin
    w_next    = r_state;
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = r_last;
    unique case (r_state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_clr_cnt;
        if (r_clr_cnt == '1) w_next = S_RUN;
      end
      S_RUN: begin
        // loader wins unless it has used its burst while fetch waits
        if (ld_valid && !(fetch_req && r_burst == MAXB)) begin
          ld_ready  = 1'b1;
          mem_addr  = ld_addr;
          mem_we    = ld_we;
          mem_wdata = ld_we ? ld_wdata : '0;
        end else if (fetch_req) begin
          fetch_gnt = 1'b1;
          mem_addr  = fetch_addr;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT;
      r_clr_cnt <= '0;
      r_last    <= '0;
      r_burst   <= '0;
      r_f_rv    <= 1'b0;
      r_l_rv    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_last  <= mem_addr;
      r_f_rv  <= fetch_gnt;
      r_l_rv  <= ld_ready & ~ld_we;
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (fetch_gnt || !fetch_req)
        r_burst <= '0;
      else if (ld_ready && r_burst != MAXB)
        r_burst <= r_burst + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f_hold <= '0;
      r_l_hold <= '0;
    end else begin
      if (r_f_rv) r_f_hold <= mem_rdata;
      if (r_l_rv) r_l_hold <= mem_rdata;
    end
  end

  assign busy         = (r_state == S_CLEAR);
  assign fetch_rvalid = r_f_rv;
  assign ld_rvalid    = r_l_rv;
  assign fetch_rdata  = r_f_rv ? mem_rdata : r_f_hold;
  assign ld_rdata     = r_l_rv ? mem_rdata : r_l_hold;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed stimulus, queued expected read data,
// and a negedge monitor that checks every returned word.
module tb_imem_arbiter;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AB-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          ld_valid;
  logic          ld_we;
  logic [AB-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_ready;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;
  logic          busy;
  logic [AB-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  imem_arbiter #(
    .IMEM_BITS(AB), .MAX_LD_BURST(2), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] fq[$];
  logic [31:0] lq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (fetch_rvalid === 1'b1) begin
      if (fq.size() == 0) chk("fetch_rvalid_unexpected", 1, 0);
      else chk("fetch_rdata", fetch_rdata, fq.pop_front());
    end
    if (ld_rvalid === 1'b1) begin
      if (lq.size() == 0) chk("ld_rvalid_unexpected", 1, 0);
      else chk("ld_rdata", ld_rdata, lq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  bit          exp_l [6] = '{1, 1, 0, 1, 1, 0};
  logic [3:0]  f_a   [6] = '{0, 1, 2, 8, 9, 10};
  logic [31:0] f_d   [6] = '{0, 0, 0, 32'h100, 32'h101, 32'h102};

  initial begin
    int k;
    reset = 1'b0; fetch_req = 0; fetch_addr = '0;
    ld_valid = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", busy, 1);
    chk("rst_frv", fetch_rvalid, 0);
    chk("rst_lrv", ld_rvalid, 0);
    chk("rst_frd", fetch_rdata, 0);
    chk("rst_lrd", ld_rdata, 0);

    @(negedge clk);
    reset = 1'b1; fetch_req = 1; ld_valid = 1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      chk("clr_busy", busy, 1);
      chk("clr_we", mem_we, 1);
      chk("clr_addr", mem_addr, i);
      chk("clr_wdata", mem_wdata, 0);
      chk("clr_fgnt", fetch_gnt, 0);
      chk("clr_lrdy", ld_ready, 0);
    end
    fetch_req = 0; ld_valid = 0;
    @(negedge clk); #2;
    chk("clr_done_busy", busy, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_addr_hold", mem_addr, 15);

    // restart the clear part-way through
    @(negedge clk); reset = 1'b0; #2;
    chk("rst2_busy", busy, 1);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      chk("clr2_addr", mem_addr, i);
    end
    reset = 1'b0; #1; reset = 1'b1; #1;
    chk("clr3_addr", mem_addr, 0);
    chk("clr3_busy", busy, 1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk); #2;
      chk("clr3_addr", mem_addr, i);
      chk("clr3_busy", busy, 1);
    end
    @(negedge clk); #2;
    chk("clr3_done", busy, 0);

    // loader write and fetch to the same word in one cycle
    @(negedge clk);
    ld_valid = 1; ld_we = 1; ld_addr = 5; ld_wdata = 32'hDEADBEEF;
    fetch_req = 1; fetch_addr = 5;
    #2;
    chk("same_lrdy", ld_ready, 1);
    chk("same_fgnt", fetch_gnt, 0);
    chk("same_we", mem_we, 1);
    chk("same_addr", mem_addr, 5);
    chk("same_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); ld_valid = 0; #2;
    chk("same_fgnt2", fetch_gnt, 1);
    fq.push_back(32'hDEADBEEF);
    @(negedge clk); fetch_req = 0;

    // loader burst against a waiting fetch
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ld_valid = 1; ld_we = 1;
      ld_addr = AB'(8 + k); ld_wdata = 32'h100 + k;
      fetch_req = 1; fetch_addr = 5;
      #2;
      chk("burst_lrdy", ld_ready, exp_l[c]);
      chk("burst_fgnt", fetch_gnt, !exp_l[c]);
      if (exp_l[c]) k++;
      else fq.push_back(32'hDEADBEEF);
    end
    @(negedge clk);
    ld_valid = 0; fetch_req = 0;

    // loader write then read back
    @(negedge clk);
    ld_valid = 1; ld_we = 1; ld_addr = 3; ld_wdata = 32'h12345678;
    #2; chk("ldw_rdy", ld_ready, 1);
    @(negedge clk);
    ld_we = 0; #2;
    chk("ldr_rdy", ld_ready, 1);
    chk("ldr_we", mem_we, 0);
    chk("ldr_addr", mem_addr, 3);
    lq.push_back(32'h12345678);
    @(negedge clk); ld_valid = 0; #2;
    chk("ldr_rv", ld_rvalid, 1);
    chk("ldr_no_frv", fetch_rvalid, 0);

    // back-to-back fetches
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      fetch_req = 1; fetch_addr = f_a[c];
      #2;
      chk("b2b_fgnt", fetch_gnt, 1);
      chk("b2b_addr", mem_addr, f_a[c]);
      fq.push_back(f_d[c]);
    end
    @(negedge clk); fetch_req = 0; #2;
    chk("end_we", mem_we, 0);
    chk("end_addr_hold", mem_addr, 10);
    @(negedge clk); #2;
    chk("end_frv", fetch_rvalid, 0);
    chk("end_frd_hold", fetch_rdata, 32'h102);
    chk("end_lrd_hold", ld_rdata, 32'h12345678);
    repeat (2) @(negedge clk);
    #2;
    chk("fq_drained", fq.size(), 0);
    chk("lq_drained", lq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
